// File: rtl/uart_receiver.sv
// UART receive deserialiser: oversampled start/data/parity/stop framing, one done pulse per frame.
// Optional build macro UART_RX_MAJORITY_VOTE_EN enables 2-of-3 majority sampling of every bit.
module uart_receiver #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  input  logic       baud_rt_tick_i,
  input  logic [1:0] data_width_i,
  input  logic       parity_en_i,
  input  logic       stop_bits_i,
  output logic [7:0] data_rx_o,
  output logic       parity_o,
  output logic       frame_error_o,
  output logic       rx_done_o,
  output logic       is_receiving_o
);

  localparam int CNT_W = $clog2(OVERSAMPLE + 1);
  localparam logic [CNT_W-1:0] BIT_EVAL = CNT_W'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
  // Start evaluation is shifted by one tick, which re-centres every later vote window.
  localparam logic [CNT_W-1:0] START_EVAL = CNT_W'(OVERSAMPLE / 2);
`else
  localparam logic [CNT_W-1:0] START_EVAL = CNT_W'(OVERSAMPLE / 2 - 1);
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [CNT_W-1:0]       cnt;
  logic [2:0]             idx;
  logic [7:0]             shift;
  logic                   par_q;
  logic                   err_q;
  logic                   stop_idx;
  logic [1:0]             cfg_width;
  logic                   cfg_par;
  logic                   cfg_stop;
  logic [CNT_W-1:0]       eval_pt;
  logic                   at_eval;
  logic                   bit_val;
  logic [2:0]             last_idx;
`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0]             votes;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
  end

  assign rxs      = sync_q[SYNC_STAGES-1];
  assign last_idx = 3'd4 + {1'b0, cfg_width};

  always_comb begin
    eval_pt = (state == START) ? START_EVAL : BIT_EVAL;
    at_eval = baud_rt_tick_i && (cnt == eval_pt);
`ifdef UART_RX_MAJORITY_VOTE_EN
    bit_val = (votes[0] & votes[1]) | (votes[0] & rxs) | (votes[1] & rxs);
`else
    bit_val = rxs;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      cnt            <= '0;
      idx            <= '0;
      shift          <= '0;
      par_q          <= 1'b0;
      err_q          <= 1'b0;
      stop_idx       <= 1'b0;
      cfg_width      <= '0;
      cfg_par        <= 1'b0;
      cfg_stop       <= 1'b0;
      data_rx_o      <= '0;
      parity_o       <= 1'b0;
      frame_error_o  <= 1'b0;
      rx_done_o      <= 1'b0;
      is_receiving_o <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
      votes          <= '0;
`endif
    end else begin
      rx_done_o <= 1'b0;
      if (baud_rt_tick_i) cnt <= cnt + 1'b1;
`ifdef UART_RX_MAJORITY_VOTE_EN
      if (baud_rt_tick_i && state != IDLE) begin
        if (cnt == eval_pt - CNT_W'(2)) votes[0] <= rxs;
        if (cnt == eval_pt - CNT_W'(1)) votes[1] <= rxs;
      end
`endif
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rxs) begin
            state          <= START;
            is_receiving_o <= 1'b1;
            cfg_width      <= data_width_i;
            cfg_par        <= parity_en_i;
            cfg_stop       <= stop_bits_i;
          end
        end
        START: begin
          if (at_eval) begin
            cnt <= '0;
            if (!bit_val) begin
              state    <= DATA;
              idx      <= '0;
              shift    <= '0;
              par_q    <= 1'b0;
              err_q    <= 1'b0;
              stop_idx <= 1'b0;
            end else begin
              state          <= IDLE;
              is_receiving_o <= 1'b0;
            end
          end
        end
        DATA: begin
          if (at_eval) begin
            cnt        <= '0;
            shift[idx] <= bit_val;
            idx        <= idx + 3'd1;
            if (idx == last_idx) state <= cfg_par ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (at_eval) begin
            cnt   <= '0;
            par_q <= bit_val;
            state <= STOP;
          end
        end
        STOP: begin
          if (at_eval) begin
            cnt <= '0;
            if (!bit_val) err_q <= 1'b1;
            if (cfg_stop && !stop_idx) begin
              stop_idx <= 1'b1;
            end else begin
              // Outputs are registered on entry so the pulse coincides with the DONE cycle.
              state          <= DONE;
              data_rx_o      <= shift;
              parity_o       <= par_q;
              frame_error_o  <= err_q | ~bit_val;
              rx_done_o      <= 1'b1;
              is_receiving_o <= 1'b0;
            end
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames driven bit-by-bit on a 4-clock baud tick,
// expected characters queued at send time and compared when rx_done_o fires.
module tb_uart_receiver;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       rx_i = 1'b1;
  logic       baud_rt_tick_i = 1'b0;
  logic [1:0] data_width_i = 2'b11;
  logic       parity_en_i = 1'b0;
  logic       stop_bits_i = 1'b0;
  logic [7:0] data_rx_o;
  logic       parity_o;
  logic       frame_error_o;
  logic       rx_done_o;
  logic       is_receiving_o;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   exp_done = 0;
  logic prev_done = 1'b0;
  logic [1:0] div = 2'd0;

  uart_receiver #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx_i), .baud_rt_tick_i(baud_rt_tick_i),
    .data_width_i(data_width_i), .parity_en_i(parity_en_i), .stop_bits_i(stop_bits_i),
    .data_rx_o(data_rx_o), .parity_o(parity_o), .frame_error_o(frame_error_o),
    .rx_done_o(rx_done_o), .is_receiving_o(is_receiving_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    div            <= div + 2'd1;
    baud_rt_tick_i <= (div == 2'd3);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every done pulse must match the oldest queued character.
  always @(negedge clk_i) begin
    if (rx_done_o) begin
      done_cnt++;
      check("done_width", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("data_rx", {24'd0, data_rx_o}, {24'd0, e.d});
        check("parity", {31'd0, parity_o}, {31'd0, e.p});
        check("frame_error", {31'd0, frame_error_o}, {31'd0, e.fe});
      end
    end
    prev_done = rx_done_o;
  end

  task automatic hold(input logic v, input int n);
    rx_i = v;
    for (int k = 0; k < n;) begin
      @(negedge clk_i);
      if (baud_rt_tick_i) k++;
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits, input logic par_en,
                            input logic par_bit, input int nstop, input logic last_low,
                            input int mid_dw);
    logic [1:0] w;
    hold(1'b0, 16);
    check("busy_mid", {31'd0, is_receiving_o}, 32'd1);
    if (mid_dw >= 0) begin
      w = 2'(mid_dw);
      data_width_i = w;
    end
    for (int i = 0; i < nbits; i++) hold(data[i], 16);
    if (par_en) hold(par_bit, 16);
    for (int s = 0; s < nstop; s++) begin
      if (s == nstop - 1 && last_low) begin
        hold(1'b0, 11);
        hold(1'b1, 5);
      end else begin
        hold(1'b1, 16);
      end
    end
    hold(1'b1, 24);
  endtask

  task automatic after_frame(input string tag);
    check({tag, "_done_cnt"}, done_cnt, exp_done);
    check({tag, "_idle"}, {31'd0, is_receiving_o}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    check("rst_data", {24'd0, data_rx_o}, 32'd0);
    check("rst_parity", {31'd0, parity_o}, 32'd0);
    check("rst_fe", {31'd0, frame_error_o}, 32'd0);
    check("rst_done", {31'd0, rx_done_o}, 32'd0);
    check("rst_busy", {31'd0, is_receiving_o}, 32'd0);
    rst_i = 1'b0;
    hold(1'b1, 4);

    // 8N1 0xA5
    data_width_i = 2'b11; parity_en_i = 1'b0; stop_bits_i = 1'b0;
    exp_q.push_back('{d: 8'hA5, p: 1'b0, fe: 1'b0}); exp_done++;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b0, -1);
    after_frame("t1");

    // 7 bits + parity, 0x35 with parity bit 0
    data_width_i = 2'b10; parity_en_i = 1'b1;
    exp_q.push_back('{d: 8'h35, p: 1'b0, fe: 1'b0}); exp_done++;
    send_frame(8'h35, 7, 1'b1, 1'b0, 1, 1'b0, -1);
    after_frame("t2");

    // 4-tick low glitch: no pulse, outputs unchanged
    hold(1'b0, 4);
    check("glitch_busy", {31'd0, is_receiving_o}, 32'd1);
    hold(1'b1, 24);
    after_frame("t3");
    check("glitch_data", {24'd0, data_rx_o}, 32'h35);

    // 5 bits + parity 1 + two stop bits; upper bits must be zero-extended
    data_width_i = 2'b00; parity_en_i = 1'b1; stop_bits_i = 1'b1;
    exp_q.push_back('{d: 8'h0B, p: 1'b1, fe: 1'b0}); exp_done++;
    send_frame(8'hEB, 5, 1'b1, 1'b1, 2, 1'b0, -1);
    after_frame("t5bit");

    // 8N1 after a parity frame: parity_o back to 0
    data_width_i = 2'b11; parity_en_i = 1'b0; stop_bits_i = 1'b0;
    exp_q.push_back('{d: 8'h5A, p: 1'b0, fe: 1'b0}); exp_done++;
    send_frame(8'h5A, 8, 1'b0, 1'b1, 1, 1'b0, -1);
    after_frame("t8n1b");

    // 6-bit frame with width switched to 8 mid-frame: latched config wins
    data_width_i = 2'b01;
    exp_q.push_back('{d: 8'h2A, p: 1'b0, fe: 1'b0}); exp_done++;
    send_frame(8'hEA, 6, 1'b0, 1'b0, 1, 1'b0, 3);
    after_frame("tcfg");

    // 8N2 0x3C with second stop bit low
    data_width_i = 2'b11; stop_bits_i = 1'b1;
    exp_q.push_back('{d: 8'h3C, p: 1'b0, fe: 1'b1}); exp_done++;
    send_frame(8'h3C, 8, 1'b0, 1'b0, 2, 1'b1, -1);
    after_frame("t4");

    // Reset during data bit 3, then 0x81 8N1
    stop_bits_i = 1'b0;
    hold(1'b0, 16);
    hold(1'b1, 16);
    hold(1'b0, 16);
    hold(1'b0, 16);
    hold(1'b0, 4);
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    check("abort_data", {24'd0, data_rx_o}, 32'd0);
    check("abort_fe", {31'd0, frame_error_o}, 32'd0);
    check("abort_busy", {31'd0, is_receiving_o}, 32'd0);
    rst_i = 1'b0;
    hold(1'b1, 24);
    exp_q.push_back('{d: 8'h81, p: 1'b0, fe: 1'b0}); exp_done++;
    send_frame(8'h81, 8, 1'b0, 1'b0, 1, 1'b0, -1);
    after_frame("t5");

`ifdef UART_RX_MAJORITY_VOTE_EN
    // 0x00 with a 1-tick high spike at the middle of data bit 2
    exp_q.push_back('{d: 8'h00, p: 1'b0, fe: 1'b0}); exp_done++;
    hold(1'b0, 16);
    hold(1'b0, 16);
    hold(1'b0, 16);
    hold(1'b0, 8);
    hold(1'b1, 1);
    hold(1'b0, 7);
    for (int i = 3; i < 8; i++) hold(1'b0, 16);
    hold(1'b1, 16);
    hold(1'b1, 24);
    after_frame("t6");
`endif

    check("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
